// File: rtl/level_key_stepper.sv
// Two push-buttons (synchronized, debounced, auto-repeating) step a saturating
// level 0..MAX_LEVEL; the level feeds the seven-segment decoder and the effector.
module level_key_stepper #(
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int MAX_LEVEL     = 31,
    parameter int INIT_LEVEL    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_up_n,
    input  logic       i_key_down_n,
    input  logic       i_clear,
    output logic [4:0] o_level,
    output logic       o_step,
    output logic       o_at_min,
    output logic       o_at_max,
    output logic [1:0] o_dbg_state
);

    localparam int DW    = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW    = $clog2(RMAX + 1);
    localparam logic [4:0] MAX_L  = 5'(MAX_LEVEL);
    localparam logic [4:0] INIT_L = 5'(INIT_LEVEL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Index 0 is the up key, index 1 the down key; all key levels are active-low.
    logic [1:0]    sync1_q, sync2_q, stable_q, stable_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          step_req;
    logic          up_pressed, dn_pressed, latched_pressed;

    logic [4:0]    level_q, level_d;
    logic          step_q, step_d;
    logic          at_min_q, at_max_q;

    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DW'(DEBOUNCE_CYC - 1)) begin
                    stable_d[k] = ~stable_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign up_pressed      = ~stable_q[0];
    assign dn_pressed      = ~stable_q[1];
    assign latched_pressed = dir_q ? up_pressed : dn_pressed;

    // dir = 1 means up; the repeat counter expires on the cycle it holds 1.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rpt_d    = rpt_q;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_pressed ^ dn_pressed) begin
                    dir_d    = up_pressed;
                    step_req = 1'b1;
                    rpt_d    = RW'(REPEAT_DELAY);
                    state_d  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!latched_pressed) begin
                    state_d = IDLE;
                end else if (rpt_q == RW'(1)) begin
                    step_req = 1'b1;
                    rpt_d    = RW'(REPEAT_PERIOD);
                    state_d  = REPEAT;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        step_d  = 1'b0;
        if (i_clear) begin
            level_d = INIT_L;
        end else if (step_req) begin
            if (dir_d) begin
                if (level_q < MAX_L) begin
                    level_d = level_q + 5'd1;
                    step_d  = 1'b1;
                end
            end else if (level_q != 5'd0) begin
                level_d = level_q - 5'd1;
                step_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            rpt_q    <= '0;
            level_q  <= INIT_L;
            step_q   <= 1'b0;
            at_min_q <= (INIT_L == 5'd0);
            at_max_q <= (INIT_L == MAX_L);
        end else begin
            sync1_q  <= {i_key_down_n, i_key_up_n};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= db_cnt_d[k];
            state_q  <= state_d;
            dir_q    <= dir_d;
            rpt_q    <= rpt_d;
            level_q  <= level_d;
            step_q   <= step_d;
            at_min_q <= (level_d == 5'd0);
            at_max_q <= (level_d == MAX_L);
        end
    end

    assign o_level     = level_q;
    assign o_step      = step_q;
    assign o_at_min    = at_min_q;
    assign o_at_max    = at_max_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_level_key_stepper.sv
// Directed bench for level_key_stepper: a per-cycle vector table for press,
// bounce and clear, plus hand sequences for repeat, saturation, clear and reset.
module tb_level_key_stepper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n, key_dn_n, clear;
    logic [4:0] level;
    logic       step, at_min, at_max;
    logic [1:0] dbg_state;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       up_n;
        logic       dn_n;
        logic       clr;
        logic [4:0] exp_level;
        logic       exp_step;
        logic       exp_min;
        logic       exp_max;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];

    level_key_stepper #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5),
        .MAX_LEVEL    (31),
        .INIT_LEVEL   (0)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_up_n  (key_up_n),
        .i_key_down_n(key_dn_n),
        .i_clear     (clear),
        .o_level     (level),
        .o_step      (step),
        .o_at_min    (at_min),
        .o_at_max    (at_max),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    // Holds reset low for 3 cycles; returns at a negedge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_step", step, 0);
        check("rst_min", at_min, 1);
        check("rst_max", at_max, 0);
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the first o_step; lat is the number of edges since the call.
    task automatic wait_first_step(input int bound, output int lat);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic add_vec(input logic up_n, input logic dn_n, input logic clr,
                           input logic [4:0] lv, input logic st);
        vec_t v;
        v.up_n = up_n; v.dn_n = dn_n; v.clr = clr;
        v.exp_level = lv; v.exp_step = st;
        v.exp_min = (lv == 5'd0); v.exp_max = (lv == 5'd31);
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        logic [4:0] lvl;
        logic stp;
        logic [5:0] got;

        rst_n = 1'b0; key_up_n = 1'b1; key_dn_n = 1'b1; clear = 1'b0;

        // Bounce: up toggles every 2 cycles, never stable long enough.
        for (int i = 0; i < 16; i++) add_vec(((i / 2) % 2) != 0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++)  add_vec(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        // Clean 12-cycle press: step on the 7th edge, then release with no further step.
        for (int i = 0; i < 12; i++) add_vec(1'b0, 1'b1, 1'b0, (i >= 6) ? 5'd1 : 5'd0, i == 6);
        for (int i = 0; i < 8; i++)  add_vec(1'b1, 1'b1, 1'b0, 5'd1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);

        do_reset();
        check("rst_state", dbg_state, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            key_up_n = vecs[i].up_n;
            key_dn_n = vecs[i].dn_n;
            clear    = vecs[i].clr;
            @(negedge clk);
            check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d_step", i), step, vecs[i].exp_step);
            check($sformatf("vec%0d_min", i), at_min, vecs[i].exp_min);
            check($sformatf("vec%0d_max", i), at_max, vecs[i].exp_max);
        end
        clear = 1'b0;

        // Held up key: steps at T, T+20, then every 5, saturating at 31.
        key_up_n = 1'b0;
        wait_first_step(40, lat);
        check("rpt_first_lat", lat, 7);
        check("rpt_first_level", level, 1);
        lvl = 5'd1;
        for (int k = 1; k <= 190; k++) begin
            stp = 1'b0;
            if ((k == 20 || (k > 20 && (k - 20) % 5 == 0)) && lvl < 5'd31) begin
                lvl = lvl + 5'd1;
                stp = 1'b1;
            end
            exp_q.push_back({stp, lvl});
        end
        for (int k = 1; k <= 190; k++) begin
            @(negedge clk);
            got = {step, level};
            check($sformatf("rpt_k%0d", k), got, exp_q.pop_front());
        end
        check("sat_max", at_max, 1);
        check("sat_min", at_min, 0);

        key_up_n = 1'b1;
        idle_cycles(10);
        do_reset();

        // Down at zero, then both keys together from IDLE: never a step.
        key_dn_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("dn0_%0d", i), {step, level}, 6'd0);
        end
        key_dn_n = 1'b1;
        idle_cycles(10);
        check("dn0_idle", dbg_state, 0);
        key_up_n = 1'b0; key_dn_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("both_%0d", i), {step, level}, 6'd0);
        end
        key_up_n = 1'b1; key_dn_n = 1'b1;
        idle_cycles(10);
        do_reset();

        // Clear coinciding with a repeat step at level 10.
        key_up_n = 1'b0;
        wait_first_step(40, lat);
        check("clr_first_lat", lat, 7);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 60) check("clr_level10", level, 10);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_level", level, 0);
        check("clr_step", step, 0);
        check("clr_min", at_min, 1);
        idle_cycles(4);
        check("clr_hold", {step, level}, 6'd0);
        @(negedge clk);
        check("clr_next", {step, level}, {1'b1, 5'd1});

        // Reset while the up key stays held: fresh debounce, step 7 edges later.
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n < 7) check($sformatf("rsth_%0d", n), {step, level}, 6'd0);
            else       check("rsth_step", {step, level}, {1'b1, 5'd1});
        end
        key_up_n = 1'b1;
        idle_cycles(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
